// File: rtl/unary_reduce_serial.sv
// Purpose: serial AND/NAND/OR/NOR/XOR/XNOR reduction of an N-bit operand, W bits per cycle, LSB chunk first.
// Latency: out_valid rises K = ceil(N/W) edges after the accept edge (fewer with EARLY_EXIT on AND/OR families).
// Backpressure: one operand in flight; result held stable in DONE until out_ready, in_ready low until back in IDLE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, op latched on accept)
//   a [N-1:0], op [2:0] operand and op code (000 AND .. 101 XNOR, 11x reserved -> AND with err)
//   out_valid/out_ready result handshake
//   c, err, cycles      result bit, reserved-op flag, chunks consumed
module unary_reduce_serial #(
    parameter int N          = 32,
    parameter int W          = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N-1:0]                           a,
    input  logic [2:0]                             op,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   c,
    output logic                                   err,
    output logic [$clog2(((N+W-1)/W)+1)-1:0]       cycles
);

    localparam int K  = (N + W - 1) / W;
    localparam int KW = K * W;
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {BASE_AND, BASE_OR, BASE_XOR} base_t;

    state_t          state_q, state_d;
    base_t           base_q, base_dec;
    logic            inv_q, inv_dec;
    logic            err_q, err_dec;
    logic            acc_q, acc_n;
    logic [KW-1:0]   a_sh_q;
    logic [KW-1:0]   a_pad;
    logic [CW-1:0]   cnt_q;
    logic            c_q;
    logic [CW-1:0]   cycles_q;
    logic [W-1:0]    chunk;
    logic            pad_bit;
    logic            decided;
    logic            last;
    logic            finish;
    logic            take;

    // Op decode; reserved codes reduce as plain AND and raise err.
    always_comb begin
        base_dec = BASE_AND;
        inv_dec  = 1'b0;
        err_dec  = 1'b0;
        case (op)
            3'b000: begin base_dec = BASE_AND; inv_dec = 1'b0; end
            3'b001: begin base_dec = BASE_AND; inv_dec = 1'b1; end
            3'b010: begin base_dec = BASE_OR;  inv_dec = 1'b0; end
            3'b011: begin base_dec = BASE_OR;  inv_dec = 1'b1; end
            3'b100: begin base_dec = BASE_XOR; inv_dec = 1'b0; end
            3'b101: begin base_dec = BASE_XOR; inv_dec = 1'b1; end
            default: begin base_dec = BASE_AND; inv_dec = 1'b0; err_dec = 1'b1; end
        endcase
    end

    // Identity of the base op doubles as the pad value above bit N-1 and the
    // initial accumulator, so the partial last chunk cannot change the result.
    assign pad_bit = (base_dec == BASE_AND);

    always_comb begin
        a_pad        = {KW{pad_bit}};
        a_pad[N-1:0] = a;
    end

    // The operand is shifted down one chunk per fold, so the current chunk is
    // always the low W bits (no wide index mux).
    assign chunk = a_sh_q[W-1:0];

    always_comb begin
        acc_n = acc_q;
        case (base_q)
            BASE_AND: acc_n = acc_q & (&chunk);
            BASE_OR:  acc_n = acc_q | (|chunk);
            BASE_XOR: acc_n = acc_q ^ (^chunk);
            default:  acc_n = acc_q;
        endcase
    end

    assign decided = (EARLY_EXIT != 0) &&
                     (((base_q == BASE_AND) && !(&chunk)) ||
                      ((base_q == BASE_OR)  &&  (|chunk)));
    assign last    = (cnt_q == CW'(K - 1));
    assign finish  = last || decided;

    // in_ready is also gated by rst_n so it reads 0 for the whole reset pulse.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign take      = in_valid && in_ready;
    assign c         = c_q;
    assign err       = err_q;
    assign cycles    = cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take)      state_d = BUSY;
            BUSY:    if (finish)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= BASE_AND;
            inv_q    <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= 1'b0;
            a_sh_q   <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            cycles_q <= '0;
        end else begin
            if (state_q == IDLE && take) begin
                base_q <= base_dec;
                inv_q  <= inv_dec;
                err_q  <= err_dec;
                acc_q  <= pad_bit;
                a_sh_q <= a_pad;
                cnt_q  <= '0;
            end else if (state_q == BUSY) begin
                acc_q  <= acc_n;
                a_sh_q <= a_sh_q >> W;
                cnt_q  <= cnt_q + CW'(1);
                if (finish) begin
                    c_q      <= acc_n ^ inv_q;
                    cycles_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_unary_reduce_serial.sv
module tb_unary_reduce_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic        cc   [3];
    logic        ee   [3];
    logic [31:0] av   [3];
    logic [2:0]  opv  [3];
    logic [2:0]  cyc0, cyc1;
    logic [1:0]  cyc2;

    localparam int NN [3] = '{32, 32, 10};
    localparam int WW [3] = '{8, 8, 4};
    localparam int EX [3] = '{0, 1, 0};

    int   errors = 0;
    int   checks = 0;
    logic exp_act [3];
    logic exp_c   [3];
    logic exp_e   [3];
    int   exp_cyc [3];

    unary_reduce_serial #(.N(32), .W(8), .EARLY_EXIT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .op(opv[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .c(cc[0]), .err(ee[0]), .cycles(cyc0));
    unary_reduce_serial #(.N(32), .W(8), .EARLY_EXIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .op(opv[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .c(cc[1]), .err(ee[1]), .cycles(cyc1));
    unary_reduce_serial #(.N(10), .W(4), .EARLY_EXIT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2][9:0]), .op(opv[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .c(cc[2]), .err(ee[2]), .cycles(cyc2));

    function automatic int get_cyc(input int u);
        case (u)
            0:       return int'(cyc0);
            1:       return int'(cyc1);
            default: return int'(cyc2);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: reduce bit by bit over the N operand bits; the early-exit
    // cycle count is the chunk holding the first deciding bit.
    function automatic void model(input int u, input logic [31:0] a, input logic [2:0] op,
                                  output logic c, output logic e, output int cyc);
        int   n, w, k, kind, first;
        logic r;
        n = NN[u];
        w = WW[u];
        k = (n + w - 1) / w;
        e = (op[2:1] == 2'b11);
        kind = e ? 0 : (op[2] ? 2 : (op[1] ? 1 : 0));
        r = (kind == 0);
        first = -1;
        for (int i = 0; i < n; i++) begin
            if (kind == 0) r = r & a[i];
            else if (kind == 1) r = r | a[i];
            else r = r ^ a[i];
            if (first < 0 && kind != 2 && a[i] == (kind == 1)) first = i;
        end
        c = r ^ (!e && op[0]);
        cyc = (EX[u] != 0 && first >= 0) ? (first / w + 1) : k;
    endfunction

    // Every cycle a result is presented it must match the expectation armed at accept.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 3; u++) begin
                if (ov[u]) begin
                    if (!exp_act[u]) begin
                        check($sformatf("u%0d unexpected out_valid", u), 1, 0);
                    end else begin
                        check($sformatf("u%0d c", u), cc[u], exp_c[u]);
                        check($sformatf("u%0d err", u), ee[u], exp_e[u]);
                        check($sformatf("u%0d cycles", u), get_cyc(u), exp_cyc[u]);
                    end
                end
            end
        end
    end

    task automatic do_op(input int u, input logic [31:0] a, input logic [2:0] op,
                         input int lit_c, input int lit_e, input int lit_cyc, input int bp);
        logic mc, me;
        int   mcyc, n, lat;
        model(u, a, op, mc, me, mcyc);
        check($sformatf("u%0d model c a=%h op=%b", u, a, op), mc, lit_c);
        check($sformatf("u%0d model err a=%h op=%b", u, a, op), me, lit_e);
        check($sformatf("u%0d model cycles a=%h op=%b", u, a, op), mcyc, lit_cyc);
        n = 0;
        while (!ir[u] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check($sformatf("u%0d in_ready before accept", u), ir[u], 1);
        av[u] = a; opv[u] = op; iv[u] = 1'b1;
        exp_c[u] = mc; exp_e[u] = me; exp_cyc[u] = mcyc; exp_act[u] = 1'b1;
        @(posedge clk); #1;
        iv[u] = 1'b0; av[u] = ~a; opv[u] = 3'b000;
        check($sformatf("u%0d in_ready after accept", u), ir[u], 0);
        lat = 0;
        while (!ov[u] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check($sformatf("u%0d latency", u), lat, mcyc);
        for (int i = 0; i < bp; i++) begin
            iv[u] = 1'b1;
            @(posedge clk); #1;
            iv[u] = 1'b0;
            check($sformatf("u%0d stall out_valid", u), ov[u], 1);
            check($sformatf("u%0d stall in_ready", u), ir[u], 0);
        end
        ordy[u] = 1'b1;
        @(posedge clk); #1;
        ordy[u] = 1'b0;
        exp_act[u] = 1'b0;
        check($sformatf("u%0d out_valid after handoff", u), ov[u], 0);
        check($sformatf("u%0d in_ready after handoff", u), ir[u], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            iv[u] = 1'b0; ordy[u] = 1'b0; av[u] = '0; opv[u] = '0;
            exp_act[u] = 1'b0; exp_c[u] = 1'b0; exp_e[u] = 1'b0; exp_cyc[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d reset out_valid", u), ov[u], 0);
            check($sformatf("u%0d reset in_ready", u), ir[u], 0);
            check($sformatf("u%0d reset c", u), cc[u], 0);
            check($sformatf("u%0d reset err", u), ee[u], 0);
            check($sformatf("u%0d reset cycles", u), get_cyc(u), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // N=32, W=8, no early exit
        do_op(0, 32'hFFFF_FFFF, 3'b000, 1, 0, 4, 0);
        do_op(0, 32'hFFFF_FFFF, 3'b001, 0, 0, 4, 0);
        do_op(0, 32'h0000_0001, 3'b100, 1, 0, 4, 0);
        do_op(0, 32'h0000_0003, 3'b101, 1, 0, 4, 0);
        do_op(0, 32'h8000_0000, 3'b010, 1, 0, 4, 0);
        do_op(0, 32'h8000_0000, 3'b011, 0, 0, 4, 0);
        // Backpressure: five stalled cycles in DONE with in_valid pulses
        do_op(0, 32'h0F0F_0F0E, 3'b000, 0, 0, 4, 5);

        // N=32, W=8, early exit
        do_op(1, 32'hFFFF_FF00, 3'b000, 0, 0, 1, 0);
        do_op(1, 32'h0000_0000, 3'b011, 1, 0, 4, 0);
        do_op(1, 32'hFFFF_FF00, 3'b011, 0, 0, 2, 0);
        do_op(1, 32'h00FF_FFFF, 3'b001, 1, 0, 4, 0);
        do_op(1, 32'h0001_0000, 3'b100, 1, 0, 4, 2);

        // N=10, W=4: partial last chunk
        do_op(2, 32'h0000_03FF, 3'b000, 1, 0, 3, 0);
        do_op(2, 32'h0000_0200, 3'b100, 1, 0, 3, 0);
        do_op(2, 32'h0000_03FF, 3'b011, 0, 0, 3, 0);
        do_op(2, 32'h0000_0000, 3'b010, 0, 0, 3, 0);

        // Reset mid-BUSY aborts without emitting a result
        av[0] = 32'hFFFF_FFFF; opv[0] = 3'b100; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_act[0] = 1'b0;
        #1;
        check("abort out_valid", ov[0], 0);
        check("abort in_ready", ir[0], 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort c", cc[0], 0);
        check("abort cycles", get_cyc(0), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post-reset out_valid", ov[0], 0);
        end
        check("post-reset in_ready", ir[0], 1);
        do_op(0, 32'hFFFF_FFFF, 3'b110, 1, 1, 4, 0);
        do_op(0, 32'hFFFF_FFFE, 3'b111, 0, 1, 4, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
